// File: rtl/risc_pkg.sv
// Shared definitions for the branch/PC stage.
//   - Condition codes evaluated against the {C,Z,S,V} flag word.
//   - Branch mode encodings.
//   - Two-state PC sequencer enum.
//   - PC increment per sequential instruction.
// The flag word layout is {C,Z,S,V}: bit 3 = carry, bit 2 = zero,
// bit 1 = sign, bit 0 = overflow.
package risc_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;
  localparam logic [2:0] COND_S      = 3'b101;
  localparam logic [2:0] COND_NS     = 3'b110;
  localparam logic [2:0] COND_V      = 3'b111;

  localparam logic [1:0] BR_REL  = 2'b00;
  localparam logic [1:0] BR_ABS  = 2'b01;
  localparam logic [1:0] BR_CALL = 2'b10;
  localparam logic [1:0] BR_RET  = 2'b11;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pc_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   flags     in  4  effective {C,Z,S,V} flags for this cycle
//   br_cond   in  3  condition code
//   cond_true out 1  condition holds
module branch_cond_eval
  import risc_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] br_cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = flags[FLAG_Z];
      COND_NZ:     cond_true = ~flags[FLAG_Z];
      COND_C:      cond_true = flags[FLAG_C];
      COND_NC:     cond_true = ~flags[FLAG_C];
      COND_S:      cond_true = flags[FLAG_S];
      COND_NS:     cond_true = ~flags[FLAG_S];
      COND_V:      cond_true = flags[FLAG_V];
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC and branch-resolution stage downstream of the ALU.
// Latches ALU flags, resolves branches against them (same-cycle forwarding
// when flags_valid is high), redirects the PC and squashes one wrong-path
// instruction through a FLUSH state.
// Ports:
//   clk, rst            clock, async active-high reset
//   flags_valid         latch {carry_in,zero_in,sign_in,ovf_in} this cycle
//   br_valid/cond/mode  branch request, condition code, addressing mode
//   br_offset           signed byte offset (relative and call)
//   br_target           absolute target (register-absolute)
//   stall               hold pc/state/link/flush, clear taken
//   pc                  current PC
//   taken               one-cycle pulse marking a redirect
//   flush               high while in FLUSH (doubles as the FSM state view)
//   link_addr           saved return address
//   flags               {C,Z,S,V} flag register
//
// Handshake: a branch is consumed only on an unstalled edge in RUN. While
// stalled the upstream stage holds br_* stable; a branch seen in FLUSH is
// wrong-path and dropped.
module branch_pc_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flags_valid,
  input  logic        carry_in,
  input  logic        zero_in,
  input  logic        sign_in,
  input  logic        ovf_in,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [1:0]  br_mode,
  input  logic [31:0] br_offset,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        taken,
  output logic        flush,
  output logic [31:0] link_addr,
  output logic [3:0]  flags
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] link_q, link_d;
  logic        taken_q, taken_d;
  logic [3:0]  flags_q;

  logic [3:0]  flags_inc;
  logic [3:0]  eff_flags;
  logic        cond_true;
  logic        br_take;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign flags_inc = {carry_in, zero_in, sign_in, ovf_in};
  // Forward the ALU flags produced this cycle so a compare+branch pair
  // resolves without a bubble.
  assign eff_flags = flags_valid ? flags_inc : flags_q;

  branch_cond_eval u_cond (
    .flags     (eff_flags),
    .br_cond   (br_cond),
    .cond_true (cond_true)
  );

  // Call and return ignore the condition code.
  assign br_take = br_valid &&
                   ((br_mode == BR_CALL) || (br_mode == BR_RET) || cond_true);

  always_comb begin
    raw_target = pc_q + br_offset;
    unique case (br_mode)
      BR_REL:  raw_target = pc_q + br_offset;
      BR_ABS:  raw_target = br_target;
      BR_CALL: raw_target = pc_q + br_offset;
      BR_RET:  raw_target = link_q;
      default: raw_target = pc_q + br_offset;
    endcase
  end

  assign target = {raw_target[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        ST_RUN:   if (br_take) state_d = ST_FLUSH;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    pc_d    = pc_q;
    link_d  = link_q;
    taken_d = 1'b0;
    if (!stall) begin
      if (state_q == ST_FLUSH) begin
        pc_d = pc_q + PC_STEP;
      end else if (br_take) begin
        pc_d    = target;
        taken_d = 1'b1;
        if (br_mode == BR_CALL) link_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      link_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
    end
  end

  // Flags latch independently of stall and sequencer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              flags_q <= '0;
    else if (flags_valid) flags_q <= flags_inc;
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign flush     = (state_q == ST_FLUSH);
  assign link_addr = link_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        flags_valid;
  logic        carry_in, zero_in, sign_in, ovf_in;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [1:0]  br_mode;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic        stall;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic [31:0] link_addr;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_link;
  logic [3:0]  m_flags;
  logic        m_taken;
  logic        m_squash;
  logic [31:0] exp_q[$];

  branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .flags_valid (flags_valid),
    .carry_in    (carry_in),
    .zero_in     (zero_in),
    .sign_in     (sign_in),
    .ovf_in      (ovf_in),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_mode     (br_mode),
    .br_offset   (br_offset),
    .br_target   (br_target),
    .stall       (stall),
    .pc          (pc),
    .taken       (taken),
    .flush       (flush),
    .link_addr   (link_addr),
    .flags       (flags)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    flags_valid = 1'b0;
    carry_in = 1'b0; zero_in = 1'b0; sign_in = 1'b0; ovf_in = 1'b0;
    br_valid = 1'b0; br_cond = 3'd0; br_mode = 2'd0;
    br_offset = '0; br_target = '0;
    stall = 1'b0;
  endtask

  task automatic drive_flags(input logic c, input logic z, input logic s, input logic v);
    flags_valid = 1'b1;
    carry_in = c; zero_in = z; sign_in = s; ovf_in = v;
  endtask

  task automatic drive_branch(input logic [1:0] mode, input logic [2:0] cond,
                              input logic [31:0] off, input logic [31:0] tgt);
    br_valid = 1'b1; br_mode = mode; br_cond = cond;
    br_offset = off; br_target = tgt;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_link = 32'h0; m_flags = 4'h0;
    m_taken = 1'b0; m_squash = 1'b0;
    exp_q.delete();
  endtask

  // Behavioural model: applies the architectural rules for one clock edge.
  task automatic model_step();
    logic [3:0]  inc, eff;
    logic        ok;
    logic [31:0] tgt;
    inc = {carry_in, zero_in, sign_in, ovf_in};
    eff = flags_valid ? inc : m_flags;
    if (stall) begin
      m_taken = 1'b0;
    end else if (m_squash) begin
      m_pc = m_pc + 32'd4;
      m_taken = 1'b0;
      m_squash = 1'b0;
    end else begin
      case (br_cond)
        3'd0: ok = 1'b1;
        3'd1: ok = eff[2];
        3'd2: ok = !eff[2];
        3'd3: ok = eff[3];
        3'd4: ok = !eff[3];
        3'd5: ok = eff[1];
        3'd6: ok = !eff[1];
        default: ok = eff[0];
      endcase
      if (br_mode == 2'd2 || br_mode == 2'd3) ok = 1'b1;
      if (br_valid && ok) begin
        if (br_mode == 2'd1)      tgt = br_target;
        else if (br_mode == 2'd3) tgt = m_link;
        else                      tgt = m_pc + br_offset;
        tgt[1:0] = 2'b00;
        if (br_mode == 2'd2) m_link = m_pc + 32'd4;
        m_pc = tgt;
        m_taken = 1'b1;
        m_squash = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
        m_taken = 1'b0;
      end
    end
    if (flags_valid) m_flags = inc;
    exp_q.push_back(m_pc);
  endtask

  // Scoreboard compare against the model after each edge
  task automatic check_all();
    logic [31:0] exp_pc;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: expected queue empty");
      return;
    end
    exp_pc = exp_q.pop_front();
    check("pc", pc, exp_pc);
    check("taken", {31'd0, taken}, {31'd0, m_taken});
    check("flush", {31'd0, flush}, {31'd0, m_squash});
    check("link_addr", link_addr, m_link);
    check("flags", {28'd0, flags}, {28'd0, m_flags});
  endtask

  // One clock: model consumes pre-edge inputs, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_flags"}, {28'd0, flags}, 32'h0);
    check({tag, "_link"}, link_addr, 32'h0);
    check({tag, "_taken"}, {31'd0, taken}, 32'h0);
    check({tag, "_flush"}, {31'd0, flush}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_reset_values("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    model_reset();
    #3;
    check_reset_values("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running after reset
    tick(); tick(); tick();
    check("free_run_pc", pc, 32'h0000_000C);

    // Forwarded Z=1 with cond Z at pc=8
    do_reset();
    tick(); tick();
    check("pre_fwd_pc", pc, 32'h8);
    drive_flags(1'b0, 1'b1, 1'b0, 1'b0);
    drive_branch(2'd0, 3'd1, 32'h20, 32'h0);
    tick();
    check("fwd_pc", pc, 32'h28);
    check("fwd_taken", {31'd0, taken}, 32'd1);
    check("fwd_flush", {31'd0, flush}, 32'd1);
    drive_idle();
    tick();
    check("after_fwd_pc", pc, 32'h2C);
    check("after_fwd_taken", {31'd0, taken}, 32'd0);

    // Latched Z=0: cond Z not taken, cond NZ taken
    drive_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_idle();
    drive_branch(2'd0, 3'd1, 32'h8, 32'h0);
    tick();
    check("latched_z_pc", pc, 32'h34);
    check("latched_z_taken", {31'd0, taken}, 32'd0);
    drive_branch(2'd0, 3'd2, 32'h8, 32'h0);
    tick();
    check("latched_nz_pc", pc, 32'h3C);
    drive_idle();
    tick();
    check("pre_call_pc", pc, 32'h40);

    // Call then return
    drive_branch(2'd2, 3'd7, 32'hFFFF_FFF0, 32'h0);
    tick();
    check("call_pc", pc, 32'h30);
    check("call_link", link_addr, 32'h44);
    drive_idle();
    tick();
    drive_branch(2'd3, 3'd5, 32'h0, 32'h0);
    tick();
    check("ret_pc", pc, 32'h44);
    drive_idle();
    tick();

    // Branch in FLUSH cycle is dropped
    drive_branch(2'd0, 3'd0, 32'h100, 32'h0);
    tick();
    check("br_pc", pc, 32'h148);
    tick();
    check("flush_drop_pc", pc, 32'h14C);
    check("flush_drop_taken", {31'd0, taken}, 32'd0);

    // Stall holding a taken branch, then stall inside FLUSH
    drive_branch(2'd0, 3'd0, 32'h10, 32'h0);
    stall = 1'b1;
    tick(); tick();
    check("stall_pc", pc, 32'h14C);
    check("stall_taken", {31'd0, taken}, 32'd0);
    stall = 1'b0;
    tick();
    check("unstall_pc", pc, 32'h15C);
    drive_idle();
    stall = 1'b1;
    tick();
    check("stall_flush_hold", {31'd0, flush}, 32'd1);
    check("stall_flush_taken", {31'd0, taken}, 32'd0);
    stall = 1'b0;
    tick();
    check("stall_flush_clear", {31'd0, flush}, 32'd0);
    check("stall_flush_pc", pc, 32'h160);

    // Wrap at the top of the address space (unaligned target gets aligned)
    drive_branch(2'd1, 3'd0, 32'h0, 32'hFFFF_FFFB);
    tick();
    check("abs_pc", pc, 32'hFFFF_FFF8);
    drive_idle();
    tick();
    tick();
    check("wrap_pc", pc, 32'h0);

    // Reset asserted during FLUSH
    drive_branch(2'd1, 3'd0, 32'h0, 32'h0000_1000);
    tick();
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_flush");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      flags_valid = ($urandom_range(0, 2) == 0);
      carry_in    = ($urandom_range(0, 1) == 1);
      zero_in     = ($urandom_range(0, 1) == 1);
      sign_in     = ($urandom_range(0, 1) == 1);
      ovf_in      = ($urandom_range(0, 1) == 1);
      br_valid    = ($urandom_range(0, 1) == 1);
      br_cond     = 3'($urandom_range(0, 7));
      br_mode     = 2'($urandom_range(0, 3));
      br_offset   = $urandom_range(0, 1023) - 32'd512;
      br_target   = $urandom();
      stall       = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
